// File: rtl/tlb_pkg.sv
// Shared types and helpers for the Sv32 TLBs: update/tag layouts and the
// vaddr-vs-tag match rule used by both lookup and flush.
package tlb_pkg;

  localparam int unsigned PTE_G_BIT  = 5;
  localparam int unsigned VPN_W      = 10;
  // Internal storage holds the widest legal ASID; unused upper bits stay zero.
  localparam int unsigned ASID_MAX_W = 9;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN_W-1:0]      vpn1;
    logic [VPN_W-1:0]      vpn0;
    logic [ASID_MAX_W-1:0] asid;
    logic [31:0]           content;
  } tlb_update_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN_W-1:0]      vpn0;
    logic [VPN_W-1:0]      vpn1;
    logic [ASID_MAX_W-1:0] asid;
  } tlb_tag_t;

  function automatic logic vaddr_match(tlb_tag_t tag, logic [31:0] vaddr);
    return (tag.vpn1 == vaddr[31:22]) && (tag.is_4M || (tag.vpn0 == vaddr[21:12]));
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU over a power-of-two set of entries. Touch port 1 wins any
// tree bit that both touch ports want to write in the same cycle.
module plru_tree #(
  parameter int unsigned TLB_ENTRIES = 4,
  localparam int unsigned IdxW = $clog2(TLB_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           touch_valid_i,
  input  logic [1:0][IdxW-1:0] touch_idx_i,
  output logic [IdxW-1:0]      victim_idx_o
);

  logic [TLB_ENTRIES-2:0] tree_q, tree_d;

  // Node numbering is heap order: children of n are 2n+1 (left) and 2n+2.
  for (genvar l = 0; l < IdxW; l++) begin : g_level
    for (genvar k = 0; k < 2**l; k++) begin : g_node
      localparam int unsigned Node = 2**l - 1 + k;
      logic [1:0] on_path;
      logic [1:0] dir;
      for (genvar t = 0; t < 2; t++) begin : g_touch
        assign on_path[t] = touch_valid_i[t] && ((touch_idx_i[t] >> (IdxW - l)) == IdxW'(k));
        assign dir[t]     = touch_idx_i[t][IdxW-1-l];
      end
      assign tree_d[Node] = on_path[1] ? ~dir[1] :
                            on_path[0] ? ~dir[0] : tree_q[Node];
    end
  end

  // Exactly one leaf has every bit on its path pointing toward it.
  logic [TLB_ENTRIES-1:0] leaf_sel;
  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_leaf
    logic [IdxW-1:0] path_ok;
    for (genvar l = 0; l < IdxW; l++) begin : g_lvl
      localparam int unsigned Node = 2**l - 1 + (i >> (IdxW - l));
      localparam bit Dir = bit'((i >> (IdxW - 1 - l)) & 1);
      assign path_ok[l] = (tree_q[Node] == Dir);
    end
    assign leaf_sel[i] = &path_ok;
  end

  always_comb begin
    victim_idx_o = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (leaf_sel[i]) victim_idx_o = IdxW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/cva6_tlb_sv32_plru.sv
// Fully associative Sv32 TLB with tree-PLRU replacement, in-place refresh,
// G-aware selective flush and saturating hit/miss counters.
module cva6_tlb_sv32_plru import tlb_pkg::*; #(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [ASID_WIDTH-1:0]                 asid_to_be_flushed_i,
  input  logic [31:0]                           vaddr_to_be_flushed_i,
  input  logic [54+ASID_WIDTH-1:0]              update_i,
  input  logic                                  lu_access_i,
  input  logic [ASID_WIDTH-1:0]                 lu_asid_i,
  input  logic [31:0]                           lu_vaddr_i,
  output logic [31:0]                           lu_content_o,
  output logic                                  lu_is_4M_o,
  output logic                                  lu_hit_o,
  output logic [CNT_WIDTH-1:0]                  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]                  miss_cnt_o,
  output logic [TLB_ENTRIES*(ASID_WIDTH+22)-1:0] port_tags_q_o,
  output logic [TLB_ENTRIES*32-1:0]             port_content_q_o
);

  localparam int unsigned IdxW = $clog2(TLB_ENTRIES);
  localparam int unsigned TagW = ASID_WIDTH + 22;

  tlb_tag_t       tags_q    [TLB_ENTRIES];
  tlb_tag_t       tags_d    [TLB_ENTRIES];
  logic [31:0]    content_q [TLB_ENTRIES];
  logic [31:0]    content_d [TLB_ENTRIES];
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  tlb_update_t            upd;
  logic [ASID_MAX_W-1:0]  lu_asid, fl_asid;
  logic [TLB_ENTRIES-1:0] hit_vec;
  logic [IdxW-1:0]        hit_idx, upd_idx, victim_idx;
  logic                   upd_touch;
  logic [1:0][IdxW-1:0]   touch_idx;

  assign upd.valid   = update_i[53+ASID_WIDTH];
  assign upd.is_4M   = update_i[52+ASID_WIDTH];
  assign upd.vpn1    = update_i[42+ASID_WIDTH +: 10];
  assign upd.vpn0    = update_i[32+ASID_WIDTH +: 10];
  assign upd.asid    = ASID_MAX_W'(update_i[32 +: ASID_WIDTH]);
  assign upd.content = update_i[31:0];
  assign lu_asid     = ASID_MAX_W'(lu_asid_i);
  assign fl_asid     = ASID_MAX_W'(asid_to_be_flushed_i);

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      hit_vec[i] = tags_q[i].valid && vaddr_match(tags_q[i], lu_vaddr_i) &&
                   ((tags_q[i].asid == lu_asid) || content_q[i][PTE_G_BIT]);
    end
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IdxW'(i);
    end
  end

  assign lu_hit_o     = |hit_vec;
  assign lu_content_o = lu_hit_o ? content_q[hit_idx] : '0;
  assign lu_is_4M_o   = lu_hit_o & tags_q[hit_idx].is_4M;

  // Refresh an identical translation before consuming a free slot or evicting.
  always_comb begin
    logic            found_same, found_free;
    logic [IdxW-1:0] same_idx, free_idx;
    found_same = 1'b0;
    found_free = 1'b0;
    same_idx   = '0;
    free_idx   = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (tags_q[i].valid && tags_q[i].vpn1 == upd.vpn1 && tags_q[i].vpn0 == upd.vpn0 &&
          tags_q[i].asid == upd.asid && tags_q[i].is_4M == upd.is_4M) begin
        found_same = 1'b1;
        same_idx   = IdxW'(i);
      end
      if (!tags_q[i].valid) begin
        found_free = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
    upd_idx = found_same ? same_idx : (found_free ? free_idx : victim_idx);
  end

  always_comb begin
    logic asid_nz, vaddr_nz, asid_ok, va_ok;
    tags_d    = tags_q;
    content_d = content_q;
    upd_touch = 1'b0;
    asid_nz   = |asid_to_be_flushed_i;
    vaddr_nz  = |vaddr_to_be_flushed_i;
    asid_ok   = 1'b0;
    va_ok     = 1'b0;
    if (flush_i) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        asid_ok = (tags_q[i].asid == fl_asid) && !content_q[i][PTE_G_BIT];
        va_ok   = vaddr_match(tags_q[i], vaddr_to_be_flushed_i);
        if ((!asid_nz || asid_ok) && (!vaddr_nz || va_ok)) tags_d[i].valid = 1'b0;
      end
    end else if (upd.valid) begin
      tags_d[upd_idx].valid = 1'b1;
      tags_d[upd_idx].is_4M = upd.is_4M;
      tags_d[upd_idx].vpn1  = upd.vpn1;
      tags_d[upd_idx].vpn0  = upd.vpn0;
      tags_d[upd_idx].asid  = upd.asid;
      content_d[upd_idx]    = upd.content;
      upd_touch             = 1'b1;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lu_access_i) begin
      if (lu_hit_o) begin
        if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  assign touch_idx = {upd_idx, hit_idx};

  plru_tree #(
    .TLB_ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .touch_valid_i ({upd_touch, lu_access_i & lu_hit_o}),
    .touch_idx_i   (touch_idx),
    .victim_idx_o  (victim_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tags_q     <= '{default: '0};
      content_q  <= '{default: '0};
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      tags_q     <= tags_d;
      content_q  <= content_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_export
    assign port_tags_q_o[i*TagW +: TagW] = {tags_q[i].valid, tags_q[i].is_4M, tags_q[i].vpn0,
                                            tags_q[i].vpn1, tags_q[i].asid[ASID_WIDTH-1:0]};
    assign port_content_q_o[i*32 +: 32] = content_q[i];
  end

endmodule

// File: tb/tb_cva6_tlb_sv32_plru.sv
// Directed bench for cva6_tlb_sv32_plru: PLRU replacement, refresh, flush modes,
// superpages, counter saturation and reset.
module tb_cva6_tlb_sv32_plru;

  localparam int unsigned Entries = 4;
  localparam int unsigned AsidW   = 1;
  localparam int unsigned CntW    = 4;
  localparam int unsigned TagW    = AsidW + 22;

  logic                       clk = 1'b0;
  logic                       rst_ni;
  logic                       flush_i;
  logic [AsidW-1:0]           asid_to_be_flushed_i;
  logic [31:0]                vaddr_to_be_flushed_i;
  logic [54+AsidW-1:0]        update_i;
  logic                       lu_access_i;
  logic [AsidW-1:0]           lu_asid_i;
  logic [31:0]                lu_vaddr_i;
  logic [31:0]                lu_content_o;
  logic                       lu_is_4M_o;
  logic                       lu_hit_o;
  logic [CntW-1:0]            hit_cnt_o;
  logic [CntW-1:0]            miss_cnt_o;
  logic [Entries*TagW-1:0]    port_tags_q_o;
  logic [Entries*32-1:0]      port_content_q_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cva6_tlb_sv32_plru #(
    .TLB_ENTRIES (Entries),
    .ASID_WIDTH  (AsidW),
    .CNT_WIDTH   (CntW)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .asid_to_be_flushed_i  (asid_to_be_flushed_i),
    .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
    .update_i              (update_i),
    .lu_access_i           (lu_access_i),
    .lu_asid_i             (lu_asid_i),
    .lu_vaddr_i            (lu_vaddr_i),
    .lu_content_o          (lu_content_o),
    .lu_is_4M_o            (lu_is_4M_o),
    .lu_hit_o              (lu_hit_o),
    .hit_cnt_o             (hit_cnt_o),
    .miss_cnt_o            (miss_cnt_o),
    .port_tags_q_o         (port_tags_q_o),
    .port_content_q_o      (port_content_q_o)
  );

  // Expected tag slice, LSB first: asid, vpn1, vpn0, is_4M, valid.
  function automatic logic [TagW-1:0] mk_tag(logic v, logic m, logic [19:0] vpn,
                                             logic [AsidW-1:0] asid);
    return {v, m, vpn[9:0], vpn[19:10], asid};
  endfunction

  function automatic logic [TagW-1:0] tag_at(int i);
    return port_tags_q_o[i*TagW +: TagW];
  endfunction

  function automatic logic [31:0] content_at(int i);
    return port_content_q_o[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(logic m, logic [19:0] vpn, logic [AsidW-1:0] asid, logic [31:0] c);
    update_i = {1'b1, m, vpn, asid, c};
    tick();
    update_i = '0;
  endtask

  task automatic do_flush(logic [AsidW-1:0] asid, logic [31:0] vaddr);
    flush_i               = 1'b1;
    asid_to_be_flushed_i  = asid;
    vaddr_to_be_flushed_i = vaddr;
    tick();
    flush_i               = 1'b0;
    asid_to_be_flushed_i  = '0;
    vaddr_to_be_flushed_i = '0;
  endtask

  task automatic look(logic [31:0] vaddr, logic [AsidW-1:0] asid);
    lu_vaddr_i = vaddr;
    lu_asid_i  = asid;
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    flush_i = 1'b0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
    update_i = '0; lu_access_i = 1'b0; lu_asid_i = '0; lu_vaddr_i = '0;
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    look(32'h0, 1'b0);
    total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", lu_hit_o); end
    total++; if (lu_content_o !== 32'h0) begin bad++; $display("FAIL reset_content: got %h want 0", lu_content_o); end
    total++; if (lu_is_4M_o !== 1'b0) begin bad++; $display("FAIL reset_is4m: got %b want 0", lu_is_4M_o); end
    total++; if (hit_cnt_o !== '0) begin bad++; $display("FAIL reset_hitcnt: got %0d want 0", hit_cnt_o); end
    total++; if (miss_cnt_o !== '0) begin bad++; $display("FAIL reset_misscnt: got %0d want 0", miss_cnt_o); end
    total++; if (port_tags_q_o !== '0) begin bad++; $display("FAIL reset_tags: got %h want 0", port_tags_q_o); end
    total++; if (port_content_q_o !== '0) begin bad++; $display("FAIL reset_contents: got %h want 0", port_content_q_o); end
  endtask

  task automatic test_fill_plru();
    logic [Entries*TagW-1:0] exp_tags;
    int touch_list [3] = '{0, 2, 3};
    for (int i = 0; i < 4; i++) do_update(1'b0, 20'(i + 1), 1'b1, 32'h100 + 32'(i + 1));
    exp_tags = {mk_tag(1, 0, 20'h4, 1), mk_tag(1, 0, 20'h3, 1),
                mk_tag(1, 0, 20'h2, 1), mk_tag(1, 0, 20'h1, 1)};
    total++; if (port_tags_q_o !== exp_tags) begin bad++; $display("FAIL fill_tags: got %h want %h", port_tags_q_o, exp_tags); end
    foreach (touch_list[k]) begin
      look(32'(touch_list[k] + 1) << 12, 1'b1);
      lu_access_i = 1'b1;
      total++;
      if (lu_hit_o !== 1'b1 || lu_content_o !== 32'h101 + 32'(touch_list[k])) begin
        bad++; $display("FAIL touch_%0d: got hit=%b content=%h want hit=1 content=%h",
                        touch_list[k], lu_hit_o, lu_content_o, 32'h101 + 32'(touch_list[k]));
      end
      tick();
      lu_access_i = 1'b0;
    end
    total++; if (hit_cnt_o !== 4'd3) begin bad++; $display("FAIL touch_hitcnt: got %0d want 3", hit_cnt_o); end
    do_update(1'b0, 20'h5, 1'b1, 32'h105);
    exp_tags = {mk_tag(1, 0, 20'h4, 1), mk_tag(1, 0, 20'h3, 1),
                mk_tag(1, 0, 20'h5, 1), mk_tag(1, 0, 20'h1, 1)};
    total++; if (port_tags_q_o !== exp_tags) begin bad++; $display("FAIL plru_victim_tags: got %h want %h", port_tags_q_o, exp_tags); end
    total++; if (content_at(1) !== 32'h105) begin bad++; $display("FAIL plru_victim_content: got %h want 00000105", content_at(1)); end
  endtask

  task automatic test_refresh();
    logic [Entries*TagW-1:0] exp_tags;
    do_update(1'b0, 20'h1, 1'b1, 32'hDEADBEEF);
    exp_tags = {mk_tag(1, 0, 20'h4, 1), mk_tag(1, 0, 20'h3, 1),
                mk_tag(1, 0, 20'h5, 1), mk_tag(1, 0, 20'h1, 1)};
    total++; if (port_tags_q_o !== exp_tags) begin bad++; $display("FAIL refresh_tags: got %h want %h", port_tags_q_o, exp_tags); end
    total++; if (content_at(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL refresh_content0: got %h want deadbeef", content_at(0)); end
    total++; if (content_at(2) !== 32'h103) begin bad++; $display("FAIL refresh_content2: got %h want 00000103", content_at(2)); end
    look(32'h0000_1000, 1'b1);
    total++; if (lu_hit_o !== 1'b1 || lu_content_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL refresh_lookup: got hit=%b content=%h want hit=1 content=deadbeef", lu_hit_o, lu_content_o);
    end
  endtask

  task automatic test_counters();
    look(32'hABCD_E000, 1'b1);
    lu_access_i = 1'b1;
    repeat (5) tick();
    total++; if (miss_cnt_o !== 4'd5) begin bad++; $display("FAIL miss_count: got %0d want 5", miss_cnt_o); end
    repeat (15) tick();
    total++; if (miss_cnt_o !== 4'd15) begin bad++; $display("FAIL miss_saturate: got %0d want 15", miss_cnt_o); end
    total++; if (hit_cnt_o !== 4'd3) begin bad++; $display("FAIL miss_hitcnt_hold: got %0d want 3", hit_cnt_o); end
    look(32'h0000_1000, 1'b1);
    repeat (20) tick();
    lu_access_i = 1'b0;
    total++; if (hit_cnt_o !== 4'd15) begin bad++; $display("FAIL hit_saturate: got %0d want 15", hit_cnt_o); end
  endtask

  task automatic test_global_flush();
    do_reset();
    do_update(1'b0, 20'h10, 1'b1, 32'h20);
    do_update(1'b0, 20'h11, 1'b1, 32'h01);
    do_flush(1'b1, 32'h0);
    total++; if (tag_at(0) !== mk_tag(1, 0, 20'h10, 1)) begin bad++; $display("FAIL gflush_keep: got %h want %h", tag_at(0), mk_tag(1, 0, 20'h10, 1)); end
    total++; if (tag_at(1) !== mk_tag(0, 0, 20'h11, 1)) begin bad++; $display("FAIL gflush_kill: got %h want %h", tag_at(1), mk_tag(0, 0, 20'h11, 1)); end
    total++; if (content_at(1) !== 32'h01) begin bad++; $display("FAIL gflush_content_kept: got %h want 00000001", content_at(1)); end
    look(32'h0001_0000, 1'b0);
    total++; if (lu_hit_o !== 1'b1 || lu_content_o !== 32'h20) begin
      bad++; $display("FAIL global_other_asid: got hit=%b content=%h want hit=1 content=00000020", lu_hit_o, lu_content_o);
    end
    look(32'h0001_1000, 1'b1);
    total++; if (lu_hit_o !== 1'b0 || lu_content_o !== 32'h0) begin
      bad++; $display("FAIL flushed_miss: got hit=%b content=%h want hit=0 content=0", lu_hit_o, lu_content_o);
    end
  endtask

  task automatic test_superpage();
    do_update(1'b1, 20'hFFC00, 1'b0, 32'hCF);
    look(32'hFFC1_2000, 1'b0);
    total++; if (lu_hit_o !== 1'b1 || lu_is_4M_o !== 1'b1 || lu_content_o !== 32'hCF) begin
      bad++; $display("FAIL sp_hit: got hit=%b is4m=%b content=%h want 1 1 000000cf", lu_hit_o, lu_is_4M_o, lu_content_o);
    end
    look(32'hFFC1_2000, 1'b1);
    total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL sp_asid_miss: got %b want 0", lu_hit_o); end
    do_flush(1'b0, 32'hFFC0_0000);
    look(32'hFFC1_2000, 1'b0);
    total++; if (lu_hit_o !== 1'b0 || lu_is_4M_o !== 1'b0) begin
      bad++; $display("FAIL sp_flushed: got hit=%b is4m=%b want 0 0", lu_hit_o, lu_is_4M_o);
    end
    look(32'h0001_0000, 1'b1);
    total++; if (lu_hit_o !== 1'b1) begin bad++; $display("FAIL sp_flush_spares_other: got %b want 1", lu_hit_o); end
  endtask

  task automatic test_flush_update_same();
    logic any_valid;
    update_i              = {1'b1, 1'b0, 20'h20, 1'b1, 32'h77};
    flush_i               = 1'b1;
    asid_to_be_flushed_i  = '0;
    vaddr_to_be_flushed_i = '0;
    tick();
    update_i = '0;
    flush_i  = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < Entries; i++) any_valid |= tag_at(i)[TagW-1];
    total++; if (any_valid !== 1'b0) begin bad++; $display("FAIL flushall_valid: got %b want 0", any_valid); end
    total++; if (content_at(1) !== 32'hCF || content_at(0) !== 32'h20) begin
      bad++; $display("FAIL flush_drops_update: got %h/%h want 000000cf/00000020", content_at(1), content_at(0));
    end
    look(32'h0002_0000, 1'b1);
    total++; if (lu_hit_o !== 1'b0) begin bad++; $display("FAIL flush_update_lookup: got %b want 0", lu_hit_o); end
  endtask

  task automatic test_reset_mid();
    do_update(1'b0, 20'h33, 1'b1, 32'h55);
    look(32'h0003_3000, 1'b1);
    lu_access_i = 1'b1;
    tick();
    total++; if (hit_cnt_o !== 4'd1) begin bad++; $display("FAIL pre_reset_hitcnt: got %0d want 1", hit_cnt_o); end
    rst_ni   = 1'b0;
    update_i = {1'b1, 1'b0, 20'h44, 1'b1, 32'h66};
    tick();
    rst_ni      = 1'b1;
    update_i    = '0;
    lu_access_i = 1'b0;
    total++; if (port_tags_q_o !== '0 || port_content_q_o !== '0) begin
      bad++; $display("FAIL midreset_state: got tags=%h content=%h want 0 0", port_tags_q_o, port_content_q_o);
    end
    total++; if (hit_cnt_o !== '0 || miss_cnt_o !== '0) begin
      bad++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
    // Cleared tree picks entry 0 once all entries are full again.
    for (int i = 0; i < 4; i++) do_update(1'b0, 20'h60 + 20'(i), 1'b0, 32'h1);
    do_update(1'b0, 20'h70, 1'b0, 32'h2);
    total++; if (tag_at(0) !== mk_tag(1, 0, 20'h70, 0)) begin
      bad++; $display("FAIL midreset_plru: got %h want %h", tag_at(0), mk_tag(1, 0, 20'h70, 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill_plru();
    test_refresh();
    test_counters();
    test_global_flush();
    test_superpage();
    test_flush_update_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
